// File: rtl/riscv_decode_pkg.sv
// rtl/riscv_decode_pkg.sv - opcode constants, unit encoding and unit-select helper for decode/issue
package riscv_decode_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        EXEC   = 2'd0,
        LSU    = 2'd1,
        CSR    = 2'd2,
        MULDIV = 2'd3
    } unit_e;

    // Route an instruction to its execution unit; anything unrecognised goes to exec.
    function automatic unit_e unit_sel(input logic [31:0] instr);
        logic [6:0] opc;
        opc = instr[6:0];
        if (opc == OP && instr[31:25] == FUNCT7_MULDIV) return MULDIV;
        if (opc == LOAD || opc == STORE)                return LSU;
        if (opc == SYSTEM)                              return CSR;
        return EXEC;
    endfunction

endpackage

// File: rtl/riscv_issue_fifo.sv
// rtl/riscv_issue_fifo.sv - circular instruction buffer with push, pop, flush, full and empty
module riscv_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic w_push;
    logic w_pop;

    assign full   = (r_count == FULL_CNT);
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wdata;
    end

endmodule

// File: rtl/riscv_decode_issue_q.sv
// rtl/riscv_decode_issue_q.sv - decode/issue stage with queue, scoreboard, regfile and writeback bypass
module riscv_decode_issue_q
    import riscv_decode_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int NUM_WB = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            fetch_instr_i,
    input  logic [XLEN-1:0]        fetch_pc_i,
    input  logic                   fetch_valid_i,
    output logic                   fetch_accept_o,
    input  logic                   branch_request_i,
    input  logic [XLEN-1:0]        branch_pc_i,
    output logic                   fetch_branch_o,
    output logic [XLEN-1:0]        fetch_branch_pc_o,
    input  logic [3:0]             unit_stall_i,
    output logic                   issue_valid_o,
    output logic [1:0]             issue_unit_o,
    output logic [31:0]            issue_instr_o,
    output logic [XLEN-1:0]        issue_pc_o,
    output logic [4:0]             issue_rd_o,
    output logic [4:0]             issue_ra_o,
    output logic [4:0]             issue_rb_o,
    output logic [XLEN-1:0]        issue_ra_value_o,
    output logic [XLEN-1:0]        issue_rb_value_o,
    input  logic [NUM_WB-1:0]      wb_valid_i,
    input  logic [5*NUM_WB-1:0]    wb_idx_i,
    input  logic [XLEN*NUM_WB-1:0] wb_value_i,
    input  logic [NUM_WB-1:0]      wb_squash_i
);

    logic [31:0]     r_sb;
    logic [XLEN-1:0] r_rf [32];
    logic            r_branch;
    logic [XLEN-1:0] r_branch_pc;

    logic [31+XLEN:0] w_head;
    logic [31:0]      w_instr;
    logic [XLEN-1:0]  w_pc;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic [6:0]       w_opc;
    logic [4:0]       w_rd;
    logic [4:0]       w_ra;
    logic [4:0]       w_rb;
    unit_e            w_unit;
    logic             w_ra_used;
    logic             w_rb_used;
    logic             w_rd_used;
    logic [31:0]      w_wb_clr;
    logic [NUM_WB-1:0] w_wb_we;
    logic [31:0]      w_sb_busy;
    logic [31:0]      w_sb_set;
    logic             w_hazard;
    logic             w_issue;
    logic [XLEN-1:0]  w_ra_value;
    logic [XLEN-1:0]  w_rb_value;

    // Redirect drops any same-cycle fetch so the flushed queue restarts clean.
    assign w_push = fetch_valid_i & ~w_full & ~branch_request_i;

    riscv_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32 + XLEN)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (w_push),
        .pop   (w_issue),
        .flush (branch_request_i),
        .wdata ({fetch_instr_i, fetch_pc_i}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_instr   = w_head[31+XLEN:XLEN];
    assign w_pc      = w_head[XLEN-1:0];
    assign w_opc     = w_instr[6:0];
    assign w_rd      = w_instr[11:7];
    assign w_ra      = w_instr[19:15];
    assign w_rb      = w_instr[24:20];
    assign w_unit    = unit_sel(w_instr);
    assign w_ra_used = !(w_opc == LUI || w_opc == AUIPC || w_opc == JAL);
    assign w_rb_used = (w_opc == OP || w_opc == STORE || w_opc == BRANCH);
    assign w_rd_used = !(w_opc == STORE || w_opc == BRANCH) && (w_rd != 5'd0);

    // Writeback clear mask, regfile write enables and operand bypass (later ports override earlier).
    always_comb begin
        w_wb_clr   = '0;
        w_wb_we    = '0;
        w_ra_value = r_rf[w_ra];
        w_rb_value = r_rf[w_rb];
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid_i[p]) w_wb_clr[wb_idx_i[5*p +: 5]] = 1'b1;
            w_wb_we[p] = wb_valid_i[p] & ~wb_squash_i[p] & (wb_idx_i[5*p +: 5] != 5'd0);
            if (w_wb_we[p] && wb_idx_i[5*p +: 5] == w_ra) w_ra_value = wb_value_i[XLEN*p +: XLEN];
            if (w_wb_we[p] && wb_idx_i[5*p +: 5] == w_rb) w_rb_value = wb_value_i[XLEN*p +: XLEN];
        end
    end

    // A pending bit released this cycle no longer blocks the head.
    assign w_sb_busy = r_sb & ~w_wb_clr;
    assign w_hazard  = (w_ra_used & w_sb_busy[w_ra]) |
                       (w_rb_used & w_sb_busy[w_rb]) |
                       (w_rd_used & w_sb_busy[w_rd]);
    assign w_issue   = ~w_empty & ~w_hazard & ~unit_stall_i[w_unit] & ~branch_request_i;
    assign w_sb_set  = (w_issue && w_rd_used) ? (32'd1 << w_rd) : 32'd0;

    // Scoreboard: issue sets after writeback clears, so a colliding set wins.
    always_ff @(posedge CLK) begin
        if (RST) r_sb <= '0;
        else     r_sb <= (r_sb & ~w_wb_clr) | w_sb_set;
    end

    // Register file writes in ascending port order so the highest port wins; x0 never written.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (w_wb_we[p]) r_rf[wb_idx_i[5*p +: 5]] <= wb_value_i[XLEN*p +: XLEN];
            end
        end
    end

    // Registered redirect pulse back to fetch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_branch    <= 1'b0;
            r_branch_pc <= '0;
        end else begin
            r_branch <= branch_request_i;
            if (branch_request_i) r_branch_pc <= branch_pc_i;
        end
    end

    assign fetch_accept_o    = ~w_full;
    assign fetch_branch_o    = r_branch;
    assign fetch_branch_pc_o = r_branch_pc;
    assign issue_valid_o     = w_issue;
    assign issue_unit_o      = w_unit;
    assign issue_instr_o     = w_instr;
    assign issue_pc_o        = w_pc;
    assign issue_rd_o        = w_rd;
    assign issue_ra_o        = w_ra;
    assign issue_rb_o        = w_rb;
    assign issue_ra_value_o  = w_ra_value;
    assign issue_rb_value_o  = w_rb_value;

endmodule

// File: tb/tb_riscv_decode_issue_q.sv
// tb/tb_riscv_decode_issue_q.sv - scoreboard bench for riscv_decode_issue_q
module tb_riscv_decode_issue_q;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [31:0]  fetch_instr_i = '0;
    logic [31:0]  fetch_pc_i = '0;
    logic         fetch_valid_i = 1'b0;
    logic         fetch_accept_o;
    logic         branch_request_i = 1'b0;
    logic [31:0]  branch_pc_i = '0;
    logic         fetch_branch_o;
    logic [31:0]  fetch_branch_pc_o;
    logic [3:0]   unit_stall_i = '0;
    logic         issue_valid_o;
    logic [1:0]   issue_unit_o;
    logic [31:0]  issue_instr_o;
    logic [31:0]  issue_pc_o;
    logic [4:0]   issue_rd_o;
    logic [4:0]   issue_ra_o;
    logic [4:0]   issue_rb_o;
    logic [31:0]  issue_ra_value_o;
    logic [31:0]  issue_rb_value_o;
    logic [3:0]   wb_valid_i = '0;
    logic [19:0]  wb_idx_i = '0;
    logic [127:0] wb_value_i = '0;
    logic [3:0]   wb_squash_i = '0;

    typedef struct packed {
        logic [1:0]  unit;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] rav;
        logic [31:0] rbv;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    riscv_decode_issue_q #(.DEPTH(4), .XLEN(32), .NUM_WB(4)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .fetch_instr_i     (fetch_instr_i),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_accept_o    (fetch_accept_o),
        .branch_request_i  (branch_request_i),
        .branch_pc_i       (branch_pc_i),
        .fetch_branch_o    (fetch_branch_o),
        .fetch_branch_pc_o (fetch_branch_pc_o),
        .unit_stall_i      (unit_stall_i),
        .issue_valid_o     (issue_valid_o),
        .issue_unit_o      (issue_unit_o),
        .issue_instr_o     (issue_instr_o),
        .issue_pc_o        (issue_pc_o),
        .issue_rd_o        (issue_rd_o),
        .issue_ra_o        (issue_ra_o),
        .issue_rb_o        (issue_rb_o),
        .issue_ra_value_o  (issue_ra_value_o),
        .issue_rb_value_o  (issue_rb_value_o),
        .wb_valid_i        (wb_valid_i),
        .wb_idx_i          (wb_idx_i),
        .wb_value_i        (wb_value_i),
        .wb_squash_i       (wb_squash_i)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek();
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_issue(input logic [1:0] u, input logic [31:0] ins, input logic [31:0] pc,
                                input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] rav, input logic [31:0] rbv);
        exp_t e;
        e = '{unit: u, instr: ins, pc: pc, rd: rd, ra: ra, rb: rb, rav: rav, rbv: rbv};
        exp_q.push_back(e);
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        fetch_instr_i = ins;
        fetch_pc_i    = pc;
        fetch_valid_i = 1'b1;
        step();
        fetch_valid_i = 1'b0;
    endtask

    // Monitor: every issued instruction must match the oldest expected entry.
    always @(negedge CLK) begin
        exp_t e;
        exp_t got;
        if (!RST && issue_valid_o) begin
            n_vec++;
            got = {issue_unit_o, issue_instr_o, issue_pc_o, issue_rd_o, issue_ra_o, issue_rb_o,
                   issue_ra_value_o, issue_rb_value_o};
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_issue: got pc %0h instr %0h, required no issue",
                         issue_pc_o, issue_instr_o);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_miss++;
                    $display("FAIL issue_pc_%0h: got %h required %h", e.pc, got, e);
                end
            end
        end
    end

    initial begin
        step();
        step();
        RST = 1'b0;
        peek();
        chk("reset_accept", 32'(fetch_accept_o), 32'd1);
        chk("reset_issue_valid", 32'(issue_valid_o), 32'd0);
        chk("reset_fetch_branch", 32'(fetch_branch_o), 32'd0);
        chk("reset_fetch_branch_pc", fetch_branch_pc_o, 32'd0);
        step();

        // addi x2 issues, then add x3,x2,x1 waits for x2 and takes it via bypass
        expect_issue(2'd0, 32'h00510113, 32'h10, 5'd2, 5'd2, 5'd5, 32'd0, 32'd0);
        offer(32'h00510113, 32'h10);
        expect_issue(2'd0, 32'h001101B3, 32'h14, 5'd3, 5'd2, 5'd1, 32'd7, 32'd0);
        offer(32'h001101B3, 32'h14);
        peek();
        chk("add_blocked_x2", 32'(issue_valid_o), 32'd0);
        step();
        peek();
        chk("add_blocked_x2_again", 32'(issue_valid_o), 32'd0);
        step();
        wb_valid_i = 4'b0001; wb_idx_i[4:0] = 5'd2; wb_value_i[31:0] = 32'd7;
        step();
        wb_valid_i = 4'b0010; wb_idx_i[9:5] = 5'd3; wb_value_i[63:32] = 32'h33;
        step();
        wb_valid_i = 4'b0000;

        // Fill the queue behind an exec stall
        unit_stall_i = 4'b0001;
        expect_issue(2'd0, 32'h00100013, 32'h100, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0);
        expect_issue(2'd0, 32'h00200013, 32'h104, 5'd0, 5'd0, 5'd2, 32'd0, 32'd7);
        expect_issue(2'd0, 32'h00300013, 32'h108, 5'd0, 5'd0, 5'd3, 32'd0, 32'h33);
        expect_issue(2'd0, 32'h00400013, 32'h10C, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0);
        offer(32'h00100013, 32'h100);
        offer(32'h00200013, 32'h104);
        offer(32'h00300013, 32'h108);
        offer(32'h00400013, 32'h10C);
        peek();
        chk("full_accept", 32'(fetch_accept_o), 32'd0);
        chk("stalled_no_issue", 32'(issue_valid_o), 32'd0);
        step();
        fetch_instr_i = 32'h00500013; fetch_pc_i = 32'h110; fetch_valid_i = 1'b1;
        peek();
        chk("fifth_offer_accept", 32'(fetch_accept_o), 32'd0);
        step();
        fetch_valid_i = 1'b0;
        unit_stall_i  = 4'b0000;
        peek();
        chk("no_passthru_when_full", 32'(fetch_accept_o), 32'd0);
        step();
        peek();
        chk("accept_after_pop", 32'(fetch_accept_o), 32'd1);
        step(); step(); step(); step();

        // Unit routing; lsu stall holds only the load
        unit_stall_i = 4'b0010;
        expect_issue(2'd3, 32'h02208033, 32'h200, 5'd0, 5'd1, 5'd2, 32'd0, 32'd7);
        expect_issue(2'd1, 32'h0001A003, 32'h204, 5'd0, 5'd3, 5'd0, 32'h33, 32'd0);
        expect_issue(2'd2, 32'h00000073, 32'h208, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
        offer(32'h02208033, 32'h200);
        offer(32'h0001A003, 32'h204);
        offer(32'h00000073, 32'h208);
        peek();
        chk("lsu_stall_holds", 32'(issue_valid_o), 32'd0);
        step();
        unit_stall_i = 4'b0000;
        step(); step(); step();

        // Branch flush with three queued entries and a same-cycle fetch
        unit_stall_i = 4'b0001;
        offer(32'h00100013, 32'h300);
        offer(32'h00200013, 32'h304);
        offer(32'h00300013, 32'h308);
        unit_stall_i = 4'b0000;
        branch_request_i = 1'b1; branch_pc_i = 32'h7;
        fetch_instr_i = 32'h00900013; fetch_pc_i = 32'h30C; fetch_valid_i = 1'b1;
        peek();
        chk("branch_suppresses_issue", 32'(issue_valid_o), 32'd0);
        step();
        branch_request_i = 1'b0; branch_pc_i = 32'h0; fetch_valid_i = 1'b0;
        peek();
        chk("fetch_branch_pulse", 32'(fetch_branch_o), 32'd1);
        chk("fetch_branch_pc", fetch_branch_pc_o, 32'h7);
        chk("flushed_no_issue", 32'(issue_valid_o), 32'd0);
        chk("flushed_accept", 32'(fetch_accept_o), 32'd1);
        step();
        peek();
        chk("fetch_branch_pulse_end", 32'(fetch_branch_o), 32'd0);
        step();

        // Squashed writeback releases x26 without writing; ports 0 and 3 collide on x9
        expect_issue(2'd0, 32'h00100D13, 32'h400, 5'd26, 5'd0, 5'd1, 32'd0, 32'd0);
        offer(32'h00100D13, 32'h400);
        expect_issue(2'd0, 32'h009D0033, 32'h404, 5'd0, 5'd26, 5'd9, 32'd0, 32'h416);
        offer(32'h009D0033, 32'h404);
        peek();
        chk("x26_pending_blocks", 32'(issue_valid_o), 32'd0);
        step();
        wb_valid_i = 4'b1101; wb_squash_i = 4'b0100;
        wb_idx_i   = {5'd9, 5'd26, 5'd0, 5'd9};
        wb_value_i = {32'h416, 32'hDEAD, 32'h0, 32'h2};
        step();
        wb_valid_i = 4'b0000; wb_squash_i = 4'b0000;
        expect_issue(2'd0, 32'h009D0033, 32'h408, 5'd0, 5'd26, 5'd9, 32'd0, 32'h416);
        offer(32'h009D0033, 32'h408);
        step();

        // Mid-operation reset drops the queue, scoreboard and regfile contents
        expect_issue(2'd0, 32'h00100393, 32'h500, 5'd7, 5'd0, 5'd1, 32'd0, 32'd0);
        offer(32'h00100393, 32'h500);
        step();
        unit_stall_i = 4'b0001;
        offer(32'h00100013, 32'h504);
        RST = 1'b1;
        step();
        RST = 1'b0;
        unit_stall_i = 4'b0000;
        peek();
        chk("midreset_accept", 32'(fetch_accept_o), 32'd1);
        chk("midreset_no_issue", 32'(issue_valid_o), 32'd0);
        step();
        expect_issue(2'd0, 32'h00238033, 32'h600, 5'd0, 5'd7, 5'd2, 32'd0, 32'd0);
        offer(32'h00238033, 32'h600);
        step(); step(); step();

        chk("expected_issues_left", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_decode_issue_q.md
Name: riscv_decode_issue_q

Overview:
Parametrised decode/issue stage. It sits between fetch and the four execution units (exec, lsu, csr, muldiv).
- Buffers fetched instructions in a DEPTH-entry queue.
- Tracks pending destination registers with a scoreboard and reads operands from an internal register file, with same-cycle writeback bypass.
- Issues one instruction per cycle to the selected unit.
- Supports branch flush and N writeback ports with squash.

Parameters:
DEPTH, 4, instruction queue entries (power of two, >=2)
XLEN, 32, data/PC width
NUM_WB, 4, writeback ports (port order: 0 exec, 1 mem, 2 csr, 3 muldiv)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
fetch_instr_i  in  32  fetched instruction
fetch_pc_i  in  XLEN  instruction PC
fetch_valid_i  in  1  fetch offer
fetch_accept_o  out  1  queue not full
branch_request_i  in  1  redirect/flush request
branch_pc_i  in  XLEN  redirect target
fetch_branch_o  out  1  registered redirect pulse to fetch
fetch_branch_pc_o  out  XLEN  registered redirect target
unit_stall_i  in  4  per-unit stall: [0] exec, [1] lsu, [2] csr, [3] muldiv
issue_valid_o  out  1  instruction issued this cycle
issue_unit_o  out  2  0 exec, 1 lsu, 2 csr, 3 muldiv
issue_instr_o  out  32  issued instruction
issue_pc_o  out  XLEN  issued PC
issue_rd_o / issue_ra_o / issue_rb_o  out  5 each  register indices
issue_ra_value_o / issue_rb_value_o  out  XLEN each  operand values
wb_valid_i  in  NUM_WB  writeback strobe per port
wb_idx_i  in  5*NUM_WB  destination index per port
wb_value_i  in  XLEN*NUM_WB  result per port
wb_squash_i  in  NUM_WB  release scoreboard only, no regfile write

Behaviour:
- One clock CLK. Reset RST is synchronous and active-high.
- Reset values:
  - Queue empty; fetch_accept_o=1.
  - fetch_branch_o=0, fetch_branch_pc_o=0.
  - issue_valid_o=0.
  - Scoreboard all clear; register file all zero.
- Reset asserted mid-operation discards queued entries and pending scoreboard bits on the next edge.
- Queue:
  - Push when fetch_valid_i & fetch_accept_o.
  - fetch_accept_o = !full. No pass-through when full, even if a pop occurs that cycle.
  - Simultaneous push and pop keeps the count unchanged. Pointers wrap modulo DEPTH.
- Unit select (head instruction):
  - opcode 0110011 with funct7 0000001 -> muldiv.
  - opcode 0000011 or 0100011 -> lsu.
  - opcode 1110011 -> csr.
  - All other opcodes -> exec.
- Register usage:
  - ra used unless opcode is LUI, AUIPC or JAL.
  - rb used only for R-type, store and branch.
  - rd used unless opcode is store or branch; rd=0 counts as unused.
- Hazard: the head is blocked if any used source, or a used rd, has its scoreboard bit set.
  - Exception: a bit cleared by a writeback in the same cycle does not block.
- Issue: issue_valid_o = head valid & no hazard & !unit_stall_i[unit] & !branch_request_i.
  - Combinational from the head; pop on issue.
  - Zero latency from a non-empty head. An entry pushed at edge t can issue in the cycle after t.
- Scoreboard:
  - Issue with a used rd sets bit[rd] at the edge.
  - A writeback valid (squash or not) clears bit[idx] at the edge.
  - If set and clear hit the same index in the same cycle, set wins.
- Register file:
  - Non-squashed writeback writes the value. Writes to x0 are ignored; x0 always reads 0.
  - Several ports writing the same index: the highest port number wins.
- Operand read: regfile value, bypassed by any same-cycle non-squashed writeback to that index (highest port wins).
- Branch:
  - branch_request_i flushes the queue at the edge and drops any same-cycle push; issue is suppressed that cycle.
  - fetch_branch_o pulses 1 cycle later, with fetch_branch_pc_o = branch_pc_i.
  - Scoreboard is not cleared, because in-flight instructions still write back.

Decomposition:
- Package riscv_decode_pkg:
  - Opcode constants: OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM.
  - FUNCT7_MULDIV.
  - Unit encoding typedef unit_e (EXEC, LSU, CSR, MULDIV).
- Sub-module riscv_issue_fifo: DEPTH x (32+XLEN) circular buffer with push, pop, flush, full, empty.
- Decode, scoreboard and regfile stay in the top module.

Test Plan:
- Reset, then push addi x2,x2,5 (0x00510113) at PC 0x10 -> next cycle issue_valid_o=1, unit=0, rd=2, ra=2, ra_value=0; scoreboard bit 2 set.
- Then add x3,x2,x1 (0x001101B3) -> blocked until wb port 0 writes idx 2 = 7. Issues in that same cycle with ra_value=7 via bypass.
- Fill 4 entries with unit_stall_i=4'b0001 -> fetch_accept_o=0 on the 5th offer. Release the stall -> one issue per cycle; accept returns to 1 after the first pop.
- Route 0x02208033 (mul), lw, 0x00000073 (ecall) -> issue_unit_o = 3, 1, 2 respectively. unit_stall_i[1]=1 holds only the lw.
- 3 entries queued, branch_request_i=1 with pc 0x7 and fetch_valid_i=1 -> queue empty, no issue that cycle; next cycle fetch_branch_o=1 with pc=0x7.
- wb_squash_i[2]=1, idx 26 pending -> bit 26 clears, regfile[26] unchanged. Ports 0 and 3 both write idx 9 (2, 0x416) -> regfile[9]=0x416.
